program_memory_controller: RTL and testbench

Arbitrates instruction-fetch read requests from NUM_CONSUMERS per-core fetchers onto the NUM_CHANNELS read ports of the program memory. Sits directly upstream of the program memory and directly downstream of the fetchers. Read-only: program memory is never written by the cores. Each channel runs an independent 3-state FSM and grants consumers round-robin.

---
 rtl/program_memory_controller_pkg.sv | 40 ++++
 rtl/program_memory_controller_if.sv | 14 +
 rtl/program_memory_controller.sv | 111 +++++++++++
 tb/tb_program_memory_controller.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/program_memory_controller_pkg.sv
// Shared types and the round-robin arbitration helper for the program memory controller.
package program_memory_controller_pkg;

    localparam int unsigned MAX_CONSUMERS = 32;
    localparam int unsigned PICK_IDX_BITS = 5;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        READ_WAITING = 2'd1,
        RELAYING     = 2'd2
    } chan_state_t;

    typedef struct packed {
        logic                     hit;
        logic [PICK_IDX_BITS-1:0] idx;
    } rr_pick_t;

    // First requester that is valid and unclaimed, scanning upward from start and wrapping at num.
    function automatic rr_pick_t rr_pick(
        input logic [MAX_CONSUMERS-1:0] valid,
        input logic [MAX_CONSUMERS-1:0] claimed,
        input logic [PICK_IDX_BITS-1:0] start,
        input int unsigned              num
    );
        rr_pick_t                 r;
        int unsigned              j;
        logic [PICK_IDX_BITS-1:0] jj;
        r = '0;
        for (int unsigned k = 0; k < MAX_CONSUMERS; k++) begin
            j  = (32'(start) + k) % num;
            jj = j[PICK_IDX_BITS-1:0];
            if (!r.hit && (k < num) && valid[jj] && !claimed[jj]) begin
                r.hit = 1'b1;
                r.idx = jj;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/program_memory_controller_if.sv
// Generic packed read bus: master issues valid/address, slave answers ready/data.
interface program_memory_controller_if #(
    parameter int unsigned N         = 1,
    parameter int unsigned ADDR_BITS = 6,
    parameter int unsigned DATA_BITS = 32
);
    logic [N-1:0]           read_valid;
    logic [N*ADDR_BITS-1:0] read_address;
    logic [N-1:0]           read_ready;
    logic [N*DATA_BITS-1:0] read_data;

    modport master (output read_valid, output read_address, input read_ready, input read_data);
    modport slave  (input read_valid, input read_address, output read_ready, output read_data);
endinterface

// File: rtl/program_memory_controller.sv
// Round-robin arbiter of fetcher read requests onto the program-memory read channels.
module program_memory_controller
    import program_memory_controller_pkg::*;
#(
    parameter int unsigned NUM_CONSUMERS = 4,
    parameter int unsigned NUM_CHANNELS  = 1,
    parameter int unsigned ADDR_BITS     = 6,
    parameter int unsigned DATA_BITS     = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    program_memory_controller_if.slave    consumer,
    program_memory_controller_if.master   mem
);

    localparam int unsigned CIDX_BITS = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;
    typedef logic [CIDX_BITS-1:0] cidx_t;

    chan_state_t                             r_state [NUM_CHANNELS];
    cidx_t                                   r_cur   [NUM_CHANNELS];
    cidx_t                                   r_rr    [NUM_CHANNELS];
    logic [NUM_CONSUMERS-1:0]                r_claimed;
    logic [NUM_CHANNELS-1:0]                 r_mem_valid;
    logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  r_mem_addr;
    logic [NUM_CONSUMERS-1:0]                r_cons_ready;
    logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] r_cons_data;

    logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] w_cons_addr;
    logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  w_mem_data;
    logic [NUM_CHANNELS-1:0]                 w_hit;
    cidx_t                                   w_idx [NUM_CHANNELS];
    logic [MAX_CONSUMERS-1:0]                w_claim_scan;
    rr_pick_t                                w_pick;

    assign w_cons_addr           = consumer.read_address;
    assign w_mem_data            = mem.read_data;
    assign mem.read_valid        = r_mem_valid;
    assign mem.read_address      = r_mem_addr;
    assign consumer.read_ready   = r_cons_ready;
    assign consumer.read_data    = r_cons_data;

    // Per-channel grant selection; lower channels mark their pick claimed before higher ones scan.
    always_comb begin
        w_claim_scan = MAX_CONSUMERS'(r_claimed);
        w_pick       = '0;
        for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
            w_hit[c] = 1'b0;
            w_idx[c] = '0;
        end
        for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
            if (r_state[c] == IDLE) begin
                w_pick = rr_pick(MAX_CONSUMERS'(consumer.read_valid), w_claim_scan,
                                 PICK_IDX_BITS'(r_rr[c]), NUM_CONSUMERS);
                w_hit[c] = w_pick.hit;
                w_idx[c] = w_pick.idx[CIDX_BITS-1:0];
                if (w_pick.hit) begin
                    w_claim_scan[w_pick.idx] = 1'b1;
                end
            end
        end
    end

    // Channel FSMs: grant, wait for memory, relay to the fetcher until it drops valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
                r_state[c] <= IDLE;
                r_cur[c]   <= '0;
                r_rr[c]    <= '0;
            end
            r_claimed    <= '0;
            r_mem_valid  <= '0;
            r_mem_addr   <= '0;
            r_cons_ready <= '0;
            r_cons_data  <= '0;
        end else begin
            for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
                case (r_state[c])
                    IDLE: begin
                        if (w_hit[c]) begin
                            r_mem_valid[c]       <= 1'b1;
                            r_mem_addr[c]        <= w_cons_addr[w_idx[c]];
                            r_cur[c]             <= w_idx[c];
                            r_claimed[w_idx[c]]  <= 1'b1;
                            r_rr[c]              <= (w_idx[c] == cidx_t'(NUM_CONSUMERS - 1)) ?
                                                    '0 : cidx_t'(w_idx[c] + 1'b1);
                            r_state[c]           <= READ_WAITING;
                        end
                    end
                    READ_WAITING: begin
                        if (mem.read_ready[c]) begin
                            r_mem_valid[c]            <= 1'b0;
                            r_cons_ready[r_cur[c]]    <= 1'b1;
                            r_cons_data[r_cur[c]]     <= w_mem_data[c];
                            r_state[c]                <= RELAYING;
                        end
                    end
                    RELAYING: begin
                        if (!consumer.read_valid[r_cur[c]]) begin
                            r_cons_ready[r_cur[c]] <= 1'b0;
                            r_claimed[r_cur[c]]    <= 1'b0;
                            r_state[c]             <= IDLE;
                        end
                    end
                    default: r_state[c] <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_program_memory_controller.sv
// Directed + randomized bench for program_memory_controller (1-channel and 2-channel instances).
module tb_program_memory_controller;

    localparam int BUDGET = 60;

    logic clk = 1'b0;
    logic reset;

    logic [3:0]       cv1, cv2;
    logic [3:0][5:0]  ca1, ca2;
    logic             mr1;
    logic [31:0]      md1;
    logic [1:0]       mr2;
    logic [1:0][31:0] md2;

    int n_tests = 0;
    int n_fail  = 0;
    int model_rr;

    program_memory_controller_if #(.N(4), .ADDR_BITS(6), .DATA_BITS(32)) cif1 ();
    program_memory_controller_if #(.N(1), .ADDR_BITS(6), .DATA_BITS(32)) mif1 ();
    program_memory_controller_if #(.N(4), .ADDR_BITS(6), .DATA_BITS(32)) cif2 ();
    program_memory_controller_if #(.N(2), .ADDR_BITS(6), .DATA_BITS(32)) mif2 ();

    assign cif1.read_valid   = cv1;
    assign cif1.read_address = ca1;
    assign mif1.read_ready   = mr1;
    assign mif1.read_data    = md1;
    assign cif2.read_valid   = cv2;
    assign cif2.read_address = ca2;
    assign mif2.read_ready   = mr2;
    assign mif2.read_data    = md2;

    program_memory_controller #(.NUM_CONSUMERS(4), .NUM_CHANNELS(1), .ADDR_BITS(6), .DATA_BITS(32)) dut1 (
        .clk(clk), .reset(reset), .consumer(cif1.slave), .mem(mif1.master));
    program_memory_controller #(.NUM_CONSUMERS(4), .NUM_CHANNELS(2), .ADDR_BITS(6), .DATA_BITS(32)) dut2 (
        .clk(clk), .reset(reset), .consumer(cif2.slave), .mem(mif2.master));

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [5:0] a);
        return 32'hA5A50000 | {26'd0, a};
    endfunction

    // Reference arbitration: first requesting consumer at or after the pointer.
    function automatic int rr_next(input logic [3:0] mask, input int ptr);
        for (int k = 0; k < 4; k++) begin
            if (mask[(ptr + k) % 4]) return (ptr + k) % 4;
        end
        return -1;
    endfunction

    // Registered program memory: ready/data follow valid/address by one cycle.
    always @(posedge clk) begin
        if (reset) begin
            mr1 <= 1'b0;
            md1 <= '0;
            mr2 <= '0;
            md2 <= '0;
        end else begin
            mr1 <= mif1.read_valid[0];
            md1 <= mem_word(mif1.read_address[5:0]);
            for (int ch = 0; ch < 2; ch++) begin
                mr2[ch] <= mif2.read_valid[ch];
                md2[ch] <= mem_word(mif2.read_address[ch*6 +: 6]);
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Single isolated request on the 1-channel instance; expects 3-cycle latency.
    task automatic serve1(input int i, input logic [5:0] a);
        int lat;
        bit got;
        cv1[i] = 1'b1;
        ca1[i] = a;
        lat = 0;
        got = 1'b0;
        while (!got && lat < BUDGET) begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                check("grant_mvalid", 64'(mif1.read_valid), 64'd1);
                check("grant_maddr", 64'(mif1.read_address), 64'(a));
            end
            if (cif1.read_ready[i]) got = 1'b1;
        end
        check("serve_got", 64'(got), 64'd1);
        check("serve_latency", 64'(lat), 64'd3);
        check("serve_data", 64'(cif1.read_data[i*32 +: 32]), 64'(mem_word(a)));
        model_rr = (i + 1) % 4;
        cv1[i] = 1'b0;
        @(negedge clk);
        check("serve_release", 64'(cif1.read_ready[i]), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       seen;
        logic [5:0] a0, a1, a3;
        int         served, cyc, first, lat, expi;
        int         rc [4];
        logic [3:0] rereq;
        bit         got;

        // 1: reset with random inputs, then quiet
        reset = 1'b1;
        cv1 = 4'($urandom); ca1 = 24'($urandom);
        cv2 = 4'($urandom); ca2 = 24'($urandom);
        model_rr = 0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("rst_cready1", 64'(cif1.read_ready), 64'd0);
            check("rst_cdata1", 64'(|cif1.read_data), 64'd0);
            check("rst_mvalid1", 64'(mif1.read_valid), 64'd0);
            check("rst_maddr1", 64'(mif1.read_address), 64'd0);
            check("rst_cready2", 64'(cif2.read_ready), 64'd0);
            check("rst_mvalid2", 64'(mif2.read_valid), 64'd0);
            cv1 = 4'($urandom); ca1 = 24'($urandom);
            cv2 = 4'($urandom); ca2 = 24'($urandom);
        end
        reset = 1'b0;
        cv1 = '0; cv2 = '0;
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            seen = seen | mif1.read_valid[0] | (|mif2.read_valid) | (|cif1.read_ready) | (|cif2.read_ready);
        end
        check("idle_quiet", 64'(seen), 64'd0);

        // 2: single request, then a few random single requests
        serve1(2, 6'h05);
        for (int k = 0; k < 4; k++) begin
            serve1(int'($urandom_range(3)), 6'($urandom));
        end

        // 3: all four contend on one channel, each re-requests once
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_rr = 0;
        for (int i = 0; i < 4; i++) begin
            rc[i] = 0;
            ca1[i] = 6'($urandom);
        end
        cv1 = 4'hF;
        rereq = '0;
        served = 0;
        cyc = 0;
        while (served < 8 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            for (int i = 0; i < 4; i++) begin
                if (rereq[i]) begin
                    check("rr_release", 64'(cif1.read_ready[i]), 64'd0);
                    rereq[i] = 1'b0;
                    if (rc[i] < 2) begin
                        cv1[i] = 1'b1;
                        ca1[i] = 6'($urandom);
                    end
                end
            end
            for (int i = 0; i < 4; i++) begin
                if (cif1.read_ready[i] && cv1[i]) begin
                    expi = rr_next(cv1, model_rr);
                    check("rr_order", 64'(i), 64'(expi));
                    check("rr_data", 64'(cif1.read_data[i*32 +: 32]), 64'(mem_word(ca1[i])));
                    model_rr = (i + 1) % 4;
                    served++;
                    rc[i]++;
                    cv1[i] = 1'b0;
                    rereq[i] = 1'b1;
                end
            end
        end
        check("rr_served", 64'(served), 64'd8);
        cv1 = '0;
        @(negedge clk);
        check("rr_all_released", 64'(cif1.read_ready), 64'd0);

        // 4: two channels grant consumers 0 and 1 on the same edge
        a0 = 6'($urandom); a1 = 6'($urandom);
        ca2[0] = a0; ca2[1] = a1;
        cv2 = 4'b0011;
        @(negedge clk);
        check("dual_mvalid", 64'(mif2.read_valid), 64'd3);
        check("dual_maddr0", 64'(mif2.read_address[5:0]), 64'(a0));
        check("dual_maddr1", 64'(mif2.read_address[11:6]), 64'(a1));
        @(negedge clk);
        check("dual_early", 64'(cif2.read_ready), 64'd0);
        @(negedge clk);
        check("dual_ready", 64'(cif2.read_ready), 64'd3);
        check("dual_data0", 64'(cif2.read_data[31:0]), 64'(mem_word(a0)));
        check("dual_data1", 64'(cif2.read_data[63:32]), 64'(mem_word(a1)));
        cv2 = '0;
        @(negedge clk);
        check("dual_release", 64'(cif2.read_ready), 64'd0);

        // 5: consumer holds valid after ready, blocking the channel
        a0 = 6'($urandom); a3 = 6'($urandom);
        ca1[0] = a0; ca1[3] = a3;
        cv1 = 4'b1001;
        first = rr_next(cv1, model_rr);
        lat = 0; got = 1'b0;
        while (!got && lat < BUDGET) begin
            @(negedge clk);
            lat++;
            if (|cif1.read_ready) got = 1'b1;
        end
        check("hold_got", 64'(got), 64'd1);
        check("hold_who", 64'(cif1.read_ready), 64'(4'b0001 << first));
        check("hold_data", 64'(cif1.read_data[first*32 +: 32]), 64'(mem_word(ca1[first])));
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("hold_ready", 64'(cif1.read_ready), 64'(4'b0001 << first));
            check("hold_no_mvalid", 64'(mif1.read_valid), 64'd0);
        end
        cv1[first] = 1'b0;
        model_rr = (first + 1) % 4;
        expi = rr_next(cv1, model_rr);
        lat = 0; got = 1'b0;
        while (!got && lat < BUDGET) begin
            @(negedge clk);
            lat++;
            if (lat == 1) check("hold_release", 64'(cif1.read_ready[first]), 64'd0);
            if (|cif1.read_ready) got = 1'b1;
        end
        check("next_got", 64'(got), 64'd1);
        check("next_who", 64'(cif1.read_ready), 64'(4'b0001 << expi));
        check("next_latency", 64'(lat), 64'd4);
        check("next_data", 64'(cif1.read_data[expi*32 +: 32]), 64'(mem_word(ca1[expi])));
        model_rr = (expi + 1) % 4;
        cv1 = '0;
        @(negedge clk);
        check("next_release", 64'(cif1.read_ready), 64'd0);

        // 6: reset while the channel waits on memory
        ca1[0] = 6'($urandom);
        cv1[0] = 1'b1;
        @(negedge clk);
        check("abort_pending", 64'(mif1.read_valid), 64'd1);
        reset = 1'b1;
        cv1 = '0;
        @(negedge clk);
        check("abort_mvalid", 64'(mif1.read_valid), 64'd0);
        check("abort_maddr", 64'(mif1.read_address), 64'd0);
        check("abort_cready", 64'(cif1.read_ready), 64'd0);
        check("abort_cdata", 64'(|cif1.read_data), 64'd0);
        reset = 1'b0;
        model_rr = 0;
        @(negedge clk);
        check("abort_quiet", 64'(cif1.read_ready), 64'd0);
        serve1(1, 6'($urandom));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
